// File: rtl/mem_access_unit.sv
// Memory-side responder for decoder bus commands: owns AR/IR/DR and runs a req/ack
// handshake to the shared instruction/data memory with a bounded wait.
module mem_access_unit #(
    parameter int unsigned          DATA_W       = 16,
    parameter logic [DATA_W-1:0]    RESET_VECTOR = '0,
    parameter int unsigned          TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        rec,
    input  logic              wr,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] ar,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] dr,
    output logic              busy,
    output logic              done,
    output logic              bus_err
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ar_q, ar_d, ir_q, ir_d, dr_q, dr_d;
    logic [DATA_W-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic              req_q, req_d, we_q, we_d;
    logic              done_q, done_d, err_q, err_d;
    logic              tgt_dr_q, tgt_dr_d;
    logic [7:0]        cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        ar_d     = ar_q;
        ir_d     = ir_q;
        dr_d     = dr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        req_d    = req_q;
        we_d     = we_q;
        done_d   = 1'b0;
        err_d    = err_q;
        tgt_dr_d = tgt_dr_q;
        cnt_d    = cnt_q;

        case (state_q)
            StIdle: begin
                // A rec command wins over a simultaneous write strobe; the write is dropped.
                if (rec != 2'b00 && !wr) begin
                    err_d = 1'b1;
                end
                if (rec == 2'b01) begin
                    ar_d = alu_out;
                end else if (rec[1]) begin
                    tgt_dr_d = rec[0];
                    addr_d   = ar_q;
                    req_d    = 1'b1;
                    we_d     = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRead;
                end else if (!wr) begin
                    addr_d  = ar_q;
                    wdata_d = wdata_in;
                    req_d   = 1'b1;
                    we_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = StWrite;
                end
            end
            StRead, StWrite: begin
                // Ack takes priority over the timeout check in the same cycle.
                if (mem_ack) begin
                    if (state_q == StRead) begin
                        if (tgt_dr_q) begin
                            dr_d = mem_rdata;
                        end else begin
                            ir_d = mem_rdata;
                        end
                    end
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                req_d   = 1'b0;
                we_d    = 1'b0;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            ar_q     <= RESET_VECTOR;
            ir_q     <= '0;
            dr_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            tgt_dr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            ir_q     <= ir_d;
            dr_q     <= dr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            req_q    <= req_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
            tgt_dr_q <= tgt_dr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign ar        = ar_q;
    assign ir        = ir_q;
    assign dr        = dr_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign bus_err   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected transactions,
// a negedge monitor compares each memory transaction as it ends.
module tb_mem_access_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rec;
    logic        wr;
    logic [15:0] alu_out, wdata_in, mem_rdata;
    logic        mem_ack;
    logic        mem_req, mem_we, busy, done, bus_err;
    logic [15:0] mem_addr, mem_wdata, ar, ir, dr;

    mem_access_unit #(
        .DATA_W      (16),
        .RESET_VECTOR(16'h0000),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rec      (rec),
        .wr       (wr),
        .alu_out  (alu_out),
        .wdata_in (wdata_in),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .ar       (ar),
        .ir       (ir),
        .dr       (dr),
        .busy     (busy),
        .done     (done),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        bit          tmo;
        int          cycles;
        logic [15:0] ir;
        logic [15:0] dr;
        logic [15:0] ar;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    logic [15:0] m_ar, m_ir, m_dr;
    logic        m_err;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: tracks each mem_req burst and scores it against the queue front.
    bit   prev_req = 1'b0;
    bit   prev_done = 1'b0;
    int   req_cycles = 0;
    int   busy_cycles = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_req  = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("done_single_pulse", 16'(done), 16'd0);
            if (mem_req && !prev_req) begin
                req_cycles  = 0;
                busy_cycles = 0;
                if (q.size() == 0) begin
                    chk("unexpected_req", 16'd1, 16'd0);
                end else begin
                    cur = q[0];
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("mem_we", 16'(mem_we), 16'(cur.we));
                    if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
                end
            end
            if (mem_req) req_cycles++;
            if (busy) busy_cycles++;
            if (!mem_req && prev_req && q.size() != 0) begin
                cur = q.pop_front();
                chk("done_vs_timeout", 16'(done), 16'(!cur.tmo));
                chk("req_cycles", 16'(req_cycles), 16'(cur.cycles));
                chk("busy_cycles", 16'(busy_cycles), 16'(cur.cycles));
                chk("busy_after", 16'(busy), 16'd0);
                chk("ir", ir, cur.ir);
                chk("dr", dr, cur.dr);
                chk("ar", ar, cur.ar);
                chk("bus_err", 16'(bus_err), 16'(cur.err));
            end else if (done) begin
                chk("spurious_done", 16'(done), 16'd0);
            end
            prev_req  = mem_req;
            prev_done = done;
        end
    end

    // One command; delay = wait cycles before ack, >= TIMEOUT means memory never acks.
    task automatic do_cmd(input logic [1:0] r, input logic w, input logic [15:0] alu,
                          input logic [15:0] wd, input int delay, input logic [15:0] rd,
                          input bit poke);
        exp_t e;
        bit   xfer;
        xfer = (r[1] == 1'b1) || (r == 2'b00 && !w);
        @(negedge clk);
        rec = r; wr = w; alu_out = alu; wdata_in = wd;
        if (r != 2'b00 && !w) m_err = 1'b1;
        if (r == 2'b01) m_ar = alu;
        if (xfer) begin
            e.addr   = m_ar;
            e.we     = !r[1];
            e.wdata  = wd;
            e.tmo    = (delay >= TIMEOUT);
            e.cycles = e.tmo ? TIMEOUT : delay + 1;
            if (e.tmo) m_err = 1'b1;
            else if (r == 2'b10) m_ir = rd;
            else if (r == 2'b11) m_dr = rd;
            e.ir = m_ir; e.dr = m_dr; e.ar = m_ar; e.err = m_err;
            q.push_back(e);
        end
        @(negedge clk);
        rec = 2'b00; wr = 1'b1;
        if (xfer) begin
            for (int i = 0; i < (e.tmo ? TIMEOUT : delay); i++) begin
                if (poke) begin
                    rec = 2'($urandom_range(1, 3)); wr = 1'($urandom_range(0, 1));
                    alu_out = 16'($urandom); mem_rdata = 16'($urandom);
                end
                @(negedge clk);
            end
            rec = 2'b00; wr = 1'b1;
            if (!e.tmo) begin
                mem_ack = 1'b1; mem_rdata = rd;
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = 16'($urandom);
            end
        end else begin
            chk("idle_busy", 16'(busy), 16'd0);
            chk("idle_ar", ar, m_ar);
            mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
            @(negedge clk);
            mem_ack = 1'b0;
            chk("idle_ack_busy", 16'(busy), 16'd0);
            chk("idle_ack_done", 16'(done), 16'd0);
        end
    endtask

    initial begin
        reset = 1'b1; rec = 2'b00; wr = 1'b1; alu_out = '0; wdata_in = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        m_ar = 16'h0000; m_ir = '0; m_dr = '0; m_err = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ar", ar, 16'h0000);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_dr", dr, 16'h0000);
        chk("rst_mem_req", 16'(mem_req), 16'd0);
        chk("rst_mem_we", 16'(mem_we), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_bus_err", 16'(bus_err), 16'd0);

        mon_en = 1'b1;
        do_cmd(2'b01, 1'b1, 16'h1234, 16'h0, 0, 16'h0, 1'b0);
        do_cmd(2'b10, 1'b1, 16'h0, 16'h0, 0, 16'h8123, 1'b0);
        do_cmd(2'b01, 1'b1, 16'h0040, 16'h0, 0, 16'h0, 1'b0);
        do_cmd(2'b00, 1'b0, 16'h0, 16'hBEEF, 3, 16'h7777, 1'b0);
        do_cmd(2'b11, 1'b1, 16'h0, 16'h0, TIMEOUT + 5, 16'h0, 1'b0);
        do_cmd(2'b10, 1'b0, 16'h0, 16'hDEAD, 1, 16'h4321, 1'b0);
        do_cmd(2'b11, 1'b1, 16'h0, 16'h0, TIMEOUT - 1, 16'hA5A5, 1'b1);
        for (int n = 0; n < 40; n++) begin
            do_cmd(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
                   16'($urandom), int'($urandom_range(0, TIMEOUT + 2)), 16'($urandom),
                   1'($urandom_range(0, 1)));
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", 16'(q.size()), 16'd0);
        chk("final_bus_err", 16'(bus_err), 16'(m_err));
        chk("final_ar", ar, m_ar);
        chk("final_ir", ir, m_ir);
        chk("final_dr", dr, m_dr);
        mon_en = 1'b0;

        // Reset during the second wait cycle of a read, then a stray late ack.
        @(negedge clk); rec = 2'b10;
        @(negedge clk); rec = 2'b00;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_mem_req", 16'(mem_req), 16'd0);
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_ir", ir, 16'h0000);
        chk("midrst_ar", ar, 16'h0000);
        chk("midrst_bus_err", 16'(bus_err), 16'd0);
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_ir", ir, 16'h0000);
        chk("late_ack_dr", dr, 16'h0000);
        chk("late_ack_done", 16'(done), 16'd0);
        chk("late_ack_busy", 16'(busy), 16'd0);
        @(negedge clk);
        chk("late_ack_done2", 16'(done), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
